// File: rtl/pipeline_stall_ctrl.sv
// Pipeline freeze/flush controller: Mealy hold/flush/bubble controls, sticky stall-overrun flag.
// Optional performance counters are built only when PIPE_PERF_COUNT_EN is defined.
module pipeline_stall_ctrl #(
  parameter int unsigned MAX_STALL = 3,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_ready,
  input  logic             clr_counters,
  output logic             freeze_if,
  output logic             flush_if_id,
  output logic             bubble_id,
  output logic             freeze_back,
  output logic             stall_overrun,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] mem_wait_cycles
);

  localparam int unsigned RunW = $clog2(MAX_STALL + 2);
  localparam logic [RunW-1:0] RunMax = RunW'(MAX_STALL);
  localparam logic [RunW-1:0] RunSat = RunW'(MAX_STALL + 1);

  typedef enum logic [2:0] {
    StInit    = 3'd0,
    StRun     = 3'd1,
    StStall   = 3'd2,
    StFlush   = 3'd3,
    StMemWait = 3'd4
  } cls_e;

  cls_e            state_q, dec_cls, cls;
  logic [RunW-1:0] run_q, run_d;
  logic            overrun_q;

  always_comb begin
    dec_cls = StRun;
    if (!mem_ready)           dec_cls = StMemWait;
    else if (branch_taken)    dec_cls = StFlush;
    else if (hazard_detected) dec_cls = StStall;
    cls = (state_q == StInit) ? StInit : dec_cls;
  end

  always_comb begin
    freeze_if   = 1'b0;
    flush_if_id = 1'b0;
    bubble_id   = 1'b0;
    freeze_back = 1'b0;
    case (cls)
      StInit, StFlush: begin
        flush_if_id = 1'b1;
        bubble_id   = 1'b1;
      end
      StStall: begin
        freeze_if = 1'b1;
        bubble_id = 1'b1;
      end
      StMemWait: begin
        freeze_if   = 1'b1;
        freeze_back = 1'b1;
      end
      default: ;
    endcase
  end

  // A memory wait freezes the whole pipeline, so it must not break a stall run.
  always_comb begin
    run_d = '0;
    if (cls == StStall) begin
      run_d = (run_q == RunSat) ? run_q : run_q + RunW'(1);
    end else if (cls == StMemWait) begin
      run_d = run_q;
    end
  end

  // From INIT the next state comes straight from the priority decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StInit;
      run_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= dec_cls;
      run_q     <= run_d;
      overrun_q <= overrun_q | ((cls == StStall) && (run_q == RunMax));
    end
  end

  assign state_o       = state_q;
  assign stall_overrun = overrun_q;

`ifdef PIPE_PERF_COUNT_EN
  logic [CNT_W-1:0] stall_q, flush_q, mem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
      mem_q   <= '0;
    end else if (clr_counters) begin
      stall_q <= '0;
      flush_q <= '0;
      mem_q   <= '0;
    end else begin
      if ((cls == StStall) && !(&stall_q))   stall_q <= stall_q + CNT_W'(1);
      if ((cls == StFlush) && !(&flush_q))   flush_q <= flush_q + CNT_W'(1);
      if ((cls == StMemWait) && !(&mem_q))   mem_q   <= mem_q + CNT_W'(1);
    end
  end

  assign stall_cycles    = stall_q;
  assign flush_count     = flush_q;
  assign mem_wait_cycles = mem_q;
`else
  logic unused_clr_counters;
  assign unused_clr_counters = clr_counters;
  assign stall_cycles        = '0;
  assign flush_count         = '0;
  assign mem_wait_cycles     = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed scoreboard bench for pipeline_stall_ctrl (MAX_STALL=3, CNT_W=32).
// Counter expectations follow PIPE_PERF_COUNT_EN: modelled when defined, zero otherwise.
module tb_pipeline_stall_ctrl;

  localparam logic [2:0] C_INIT = 3'd0;
  localparam logic [2:0] C_RUN  = 3'd1;
  localparam logic [2:0] C_STL  = 3'd2;
  localparam logic [2:0] C_FLS  = 3'd3;
  localparam logic [2:0] C_MEM  = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hazard_detected, branch_taken, mem_ready, clr_counters;
  logic        freeze_if, flush_if_id, bubble_id, freeze_back, stall_overrun;
  logic [2:0]  state_o;
  logic [31:0] stall_cycles, flush_count, mem_wait_cycles;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;
  logic [31:0] m_mem   = '0;

  logic [3:0]  q_ctrl[$];
  logic [3:0]  q_reg[$];
  logic [95:0] q_cnt[$];

  pipeline_stall_ctrl #(.MAX_STALL(3), .CNT_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .hazard_detected (hazard_detected),
    .branch_taken    (branch_taken),
    .mem_ready       (mem_ready),
    .clr_counters    (clr_counters),
    .freeze_if       (freeze_if),
    .flush_if_id     (flush_if_id),
    .bubble_id       (bubble_id),
    .freeze_back     (freeze_back),
    .stall_overrun   (stall_overrun),
    .state_o         (state_o),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count),
    .mem_wait_cycles (mem_wait_cycles)
  );

  always #5 clk = ~clk;

  // {freeze_if, flush_if_id, bubble_id, freeze_back}
  function automatic logic [3:0] ctrl_of(input logic [2:0] c);
    case (c)
      C_INIT, C_FLS: return 4'b0110;
      C_STL:         return 4'b1010;
      C_MEM:         return 4'b1001;
      default:       return 4'b0000;
    endcase
  endfunction

  task automatic cmp_ctrl(input string tag);
    logic [3:0] exp_v;
    exp_v = q_ctrl.pop_front();
    tests++;
    assert ({freeze_if, flush_if_id, bubble_id, freeze_back} === exp_v) else begin
      fails++;
      $error("FAIL %s ctrl: observed %b expected %b", tag,
             {freeze_if, flush_if_id, bubble_id, freeze_back}, exp_v);
    end
  endtask

  task automatic cmp_regs(input string tag);
    logic [3:0]  exp_r;
    logic [95:0] exp_c;
    exp_r = q_reg.pop_front();
    exp_c = q_cnt.pop_front();
    tests++;
    assert ({state_o, stall_overrun} === exp_r) else begin
      fails++;
      $error("FAIL %s state/overrun: observed %b expected %b", tag,
             {state_o, stall_overrun}, exp_r);
    end
    tests++;
    assert ({stall_cycles, flush_count, mem_wait_cycles} === exp_c) else begin
      fails++;
      $error("FAIL %s counters: observed %0d/%0d/%0d expected %0d/%0d/%0d", tag,
             stall_cycles, flush_count, mem_wait_cycles,
             exp_c[95:64], exp_c[63:32], exp_c[31:0]);
    end
  endtask

  task automatic chk_reset(input string tag);
    m_stall = '0;
    m_flush = '0;
    m_mem   = '0;
    q_ctrl.push_back(4'b0110);
    q_reg.push_back({C_INIT, 1'b0});
    q_cnt.push_back(96'd0);
    cmp_ctrl(tag);
    cmp_regs(tag);
  endtask

  // Entered at a negedge; cls is the class of this cycle, nxt the state after the edge.
  task automatic step(input string tag, input logic hz, input logic br, input logic mr,
                      input logic clr, input logic [2:0] cls, input logic [2:0] nxt,
                      input logic ovr);
    hazard_detected = hz;
    branch_taken    = br;
    mem_ready       = mr;
    clr_counters    = clr;
    q_ctrl.push_back(ctrl_of(cls));
`ifdef PIPE_PERF_COUNT_EN
    if (clr) begin
      m_stall = '0;
      m_flush = '0;
      m_mem   = '0;
    end else begin
      if (cls == C_STL) m_stall = m_stall + 1;
      if (cls == C_FLS) m_flush = m_flush + 1;
      if (cls == C_MEM) m_mem   = m_mem + 1;
    end
`endif
    q_reg.push_back({nxt, ovr});
    q_cnt.push_back({m_stall, m_flush, m_mem});
    #1;
    cmp_ctrl(tag);
    @(posedge clk);
    #1;
    cmp_regs(tag);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    hazard_detected = 1'b0;
    branch_taken = 1'b0;
    mem_ready = 1'b1;
    clr_counters = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;

    step("init",       0, 0, 1, 0, C_INIT, C_RUN, 0);
    step("run0",       0, 0, 1, 0, C_RUN,  C_RUN, 0);
    step("loaduse",    1, 0, 1, 0, C_STL,  C_STL, 0);
    step("run1",       0, 0, 1, 0, C_RUN,  C_RUN, 0);
    step("br_hz",      1, 1, 1, 0, C_FLS,  C_FLS, 0);
    step("run2",       0, 0, 1, 0, C_RUN,  C_RUN, 0);
    step("memw1",      1, 0, 0, 0, C_MEM,  C_MEM, 0);
    step("memw2",      1, 1, 0, 0, C_MEM,  C_MEM, 0);
    step("memw3",      1, 0, 0, 0, C_MEM,  C_MEM, 0);
    step("mem_done",   1, 0, 1, 0, C_STL,  C_STL, 0);
    step("run3",       0, 0, 1, 0, C_RUN,  C_RUN, 0);
    // Three-stall run: no overrun.
    step("s3_a",       1, 0, 1, 0, C_STL,  C_STL, 0);
    step("s3_b",       1, 0, 1, 0, C_STL,  C_STL, 0);
    step("s3_c",       1, 0, 1, 0, C_STL,  C_STL, 0);
    step("run4",       0, 0, 1, 0, C_RUN,  C_RUN, 0);
    // Four-stall run split by a memory wait: overrun on the fourth stall.
    step("s4_a",       1, 0, 1, 0, C_STL,  C_STL, 0);
    step("s4_b",       1, 0, 1, 0, C_STL,  C_STL, 0);
    step("s4_mem",     1, 0, 0, 0, C_MEM,  C_MEM, 0);
    step("s4_c",       1, 0, 1, 0, C_STL,  C_STL, 0);
    step("s4_d",       1, 0, 1, 0, C_STL,  C_STL, 1);
    step("s4_e",       1, 0, 1, 0, C_STL,  C_STL, 1);
    step("ovr_sticky", 0, 0, 1, 0, C_RUN,  C_RUN, 1);
    step("br_only",    0, 1, 1, 0, C_FLS,  C_FLS, 1);
    step("clr_run",    0, 0, 1, 1, C_RUN,  C_RUN, 1);
    step("clr_stall",  1, 0, 1, 1, C_STL,  C_STL, 1);
    step("post_clr",   0, 1, 1, 0, C_FLS,  C_FLS, 1);

    // Asynchronous reset in the middle of a stall cycle.
    hazard_detected = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_reset("async_rst");
    @(negedge clk);
    hazard_detected = 1'b0;
    rst_n = 1'b1;
    step("init2",      1, 0, 1, 0, C_INIT, C_STL, 0);
    step("r2_a",       1, 0, 1, 0, C_STL,  C_STL, 0);
    step("r2_b",       1, 0, 1, 0, C_STL,  C_STL, 0);
    step("r2_c",       1, 0, 1, 0, C_STL,  C_STL, 0);
    step("r2_d",       1, 0, 1, 0, C_STL,  C_STL, 1);
    step("r2_run",     0, 0, 1, 0, C_RUN,  C_RUN, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central pipeline freeze/flush controller for the 5-stage ARM core. It sits directly downstream of the hazard detection unit and consumes its `hazard_detected` output, the EXE-stage `branch_taken`, and the SRAM controller's `mem_ready`. From these it drives the hold, flush and bubble controls for the PC, IF/ID, ID/EXE and back-end pipeline registers. It also tracks stall-run length for a sticky overrun flag and, optionally, keeps performance counters.

## Interface
Parameters:
- `MAX_STALL`, 3: maximum legal consecutive STALL cycles before `stall_overrun` is raised.
- `CNT_W`, 32: performance-counter width.

Ports:
- `clk` input 1: core clock. All state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `hazard_detected` input 1: from the hazard detection unit. ID instruction must wait.
- `branch_taken` input 1: from the EXE stage. Branch resolved taken this cycle.
- `mem_ready` input 1: from the SRAM controller. 0 means a memory access is in progress.
- `clr_counters` input 1: synchronous clear of the performance counters.
- `freeze_if` output 1: hold the PC and IF/ID register.
- `flush_if_id` output 1: IF/ID loads a NOP.
- `bubble_id` output 1: ID/EXE loads all-zero control signals.
- `freeze_back` output 1: hold the ID/EXE, EXE/MEM and MEM/WB registers.
- `stall_overrun` output 1: sticky; the stall run exceeded `MAX_STALL`.
- `state_o` output 3: the registered cycle class (see Operation).
- `stall_cycles`, `flush_count`, `mem_wait_cycles` output `CNT_W` each: performance counters.

## Operation
- **Cycle class encoding:** INIT=0, RUN=1, STALL=2, FLUSH=3, MEM_WAIT=4.
- **Current cycle class:** while `state_o`==INIT the class is INIT. Otherwise it is chosen by strict priority:
  1. `mem_ready`==0 → MEM_WAIT: `freeze_if`=1, `freeze_back`=1, `flush_if_id`=0, `bubble_id`=0. `hazard_detected` and `branch_taken` are ignored because they remain asserted while the pipeline is held.
  2. `branch_taken`=1 → FLUSH: `flush_if_id`=1, `bubble_id`=1, `freeze_if`=0 so the PC loads the target. A branch overrides a hazard because the ID instruction is on the wrong path.
  3. `hazard_detected`=1 → STALL: `freeze_if`=1, `bubble_id`=1, all other outputs 0.
  4. Otherwise → RUN: all four controls 0.
- **INIT class:** `flush_if_id`=1, `bubble_id`=1, `freeze_if`=0, `freeze_back`=0, regardless of inputs.
- **State register:** `state_o` <= current class on each edge. INIT therefore lasts exactly one cycle after reset release and is always followed by a class from the priority decode.
- **Run counter (`ceil(log2(MAX_STALL+2))` bits):**
  - STALL: increments, saturating at `MAX_STALL`+1.
  - MEM_WAIT: holds, so a frozen pipeline does not break the run.
  - RUN, FLUSH, INIT: clears to 0.
- **Overrun:** `stall_overrun` is set on the edge ending a STALL cycle in which the run counter equals `MAX_STALL`, i.e. the (`MAX_STALL`+1)th consecutive stall. It stays set until reset.
- **Counters (when enabled):**
  - `stall_cycles` +1 per STALL cycle, `flush_count` +1 per FLUSH cycle, `mem_wait_cycles` +1 per MEM_WAIT cycle.
  - Each saturates at all-ones.
  - `clr_counters` has priority over increment; the cycle carrying `clr_counters` is not counted.

## Timing
- The four pipeline controls are combinational (Mealy) from the current inputs and `state_o`: zero latency, valid the same cycle, and consumed by the pipeline registers at the next edge.
- `state_o`, `stall_overrun` and the counters are registered: they reflect a cycle's class one edge later.
- **Reset values (while `rst_n`=0):**
  - `state_o`=INIT, so `flush_if_id`=1 and `bubble_id`=1.
  - `freeze_if`=0, `freeze_back`=0, `stall_overrun`=0.
  - Run counter = 0, all performance counters = 0.
- **Reset mid-operation:** all registers return to reset values immediately (asynchronous). A pending stall or flush is discarded.
- **Simultaneous events:** resolved only by the priority order above. No event is queued; upstream signals must stay asserted until they are serviced.

## Configuration
- **`PIPE_PERF_COUNT_EN` defined:** the three counters and `clr_counters` behave as described above.
- **`PIPE_PERF_COUNT_EN` not defined:** the ports remain present, the counter outputs are tied to 0, `clr_counters` is ignored, and no counter flops are synthesized. All other behaviour is identical.

## Test plan
- **Reset release:** hold `rst_n`=0 with `mem_ready`=1 and other inputs 0 → `flush_if_id`=1, `bubble_id`=1, `state_o`=0. First cycle after release: unchanged. Second cycle: all controls 0; after that edge `state_o`=1.
- **Single load-use stall:** `hazard_detected`=1 for 1 cycle → `freeze_if`=1 and `bubble_id`=1 for that cycle only. Then `state_o`=2 and `stall_cycles`=1.
- **Branch with hazard:** `branch_taken`=1 and `hazard_detected`=1 in the same cycle → `flush_if_id`=1, `bubble_id`=1, `freeze_if`=0. Then `state_o`=3 and `flush_count`=1.
- **Memory wait:** `mem_ready`=0 for 3 cycles with `hazard_detected`=1 → `freeze_if`=1 and `freeze_back`=1, `bubble_id`=0; `mem_wait_cycles`=3; the run counter is unchanged. On the cycle `mem_ready` returns to 1: STALL outputs.
- **Stall overrun:** `MAX_STALL`=3, `hazard_detected`=1 for 4 consecutive cycles → `stall_overrun` goes to 1 after the 4th edge and stays 1 after the hazard drops. A 3-cycle run does not set it. Only `rst_n` clears it.
- **Counter clear and config:** `clr_counters`=1 → all counters 0 on the next edge. Build without `PIPE_PERF_COUNT_EN` → counters read 0 throughout the above scenarios.
